alu_seq_core: RTL and testbench
===============================

// Module: alu_seq_core
// PURPOSE
//  Parametrised, registered ALU for a WIDTH-bit operand pair, with a valid/ready handshake.
//  Executes eight operations: ADD, SUB, NEGA, NEGB, AND, OR, XOR and a multi-cycle
//  shift-add MUL. Results and flags (carry, zero, negative, overflow) are registered and
//  held until the consumer accepts them. Sits between the pin-level operand/opcode
//  capture and the output mux.
// PARAMETERS
//  WIDTH  4  operand width in bits; legal 2..16; result is 2*WIDTH bits
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        operand/opcode present
//  in_ready   out  1        core can accept an operation
//  op         in   3        000 ADD, 001 SUB, 010 NEGA, 011 NEGB, 100 AND, 101 OR, 110 XOR, 111 MUL
//  a          in   WIDTH    operand A (two's complement for flag purposes)
//  b          in   WIDTH    operand B
//  out_valid  out  1        result/flags valid
//  out_ready  in   1        consumer accepts result
//  result     out  2*WIDTH  result; non-MUL ops low-aligned, upper WIDTH bits 0
//  flags      out  4        {C,V,N,Z}
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; in_ready=0 while rst_n=0, then 1 in the first cycle
//   after release; out_valid=0, result=0, flags=0, multiplier regs=0.
//  FSM IDLE -> (accept, op!=MUL) -> DONE; IDLE -> (accept, op==MUL) -> MUL;
//   MUL -> (count==WIDTH-1) -> DONE; DONE -> (out_ready) -> IDLE.
//  Accept = in_valid & in_ready. in_ready = (state==IDLE) only. No accept in MUL or DONE.
//  a, b and op are sampled only on the accept edge; later input changes are ignored.
//  Latency: non-MUL ops assert out_valid in the cycle after accept (1 cycle).
//   MUL asserts out_valid WIDTH+1 cycles after accept (WIDTH iterations, 1 per cycle).
//  DONE: out_valid=1; result/flags stable and unchanged while out_ready=0.
//   The edge with out_ready=1 returns to IDLE: out_valid=0 and in_ready=1 the next cycle.
//   result/flags keep their last value (not cleared) until the next completion.
//  Arithmetic is WIDTH-bit, modulo 2^WIDTH, except MUL (unsigned, 2*WIDTH-bit full product).
//   ADD: r=a+b; C=carry out; V=signed overflow (a,b same sign, r sign differs).
//   SUB: r=a-b; C=borrow (1 when a<b unsigned); V=signed overflow (a,b differ in sign, r sign != a).
//   NEGA/NEGB: r=~x+1; V=1 iff x==100..0; C=0. NEG of 0 gives 0.
//   AND/OR/XOR: bitwise; C=0, V=0.
//   MUL: unsigned a*b, shift-add over WIDTH cycles, LSB of multiplier first; C=0, V=0.
//  N = result[WIDTH-1] for non-MUL ops, result[2*WIDTH-1] for MUL.
//  Z = (result==0) over all 2*WIDTH bits.
//  Iteration counter width: $clog2(WIDTH); it must not wrap before WIDTH-1 is reached.
//  rst_n low mid-MUL or in DONE: the operation is abandoned; no out_valid pulse follows.
//  in_valid held high with in_ready=0 is not an error; the op is taken when IDLE is reached.
// TESTING (WIDTH=4 unless noted)
//  1. Reset: rst_n=0 at any state -> out_valid=0, result=0, flags=0; in_ready=1 the cycle after release.
//  2. ADD a=9 b=8 -> 1 cycle later result=0x01, {C,V,N,Z}=1100.
//     SUB a=3 b=5 -> result=0x0E, flags=1010.
//  3. MUL a=F b=F -> out_valid exactly 5 cycles after accept; result=0xE1, flags=0010.
//     MUL a=0 b=7 -> result=0x00, Z=1.
//  4. NEGA a=8 -> result=0x08, V=1, N=1.
//     NEGB b=0 -> result=0, Z=1. XOR a=A b=A -> 0, Z=1.
//  5. Backpressure: out_ready=0 for 3 cycles -> result/flags stable, in_ready=0, a new
//     in_valid is not taken. Raise out_ready -> IDLE; the pending op is accepted next cycle.
//  6. Reset mid-MUL (cycle 2), then WIDTH=8 MUL a=0xFF b=0xFF -> no stale out_valid;
//     result=0xFE01 after 9 cycles.

Source files
------------

// File: rtl/alu_seq_core.sv
// ============================================================================
//  Module   : alu_seq_core
//  Purpose  : Registered WIDTH-bit ALU with valid/ready handshake; single-cycle
//             ADD/SUB/NEG/logic ops and a WIDTH-cycle shift-add unsigned MUL.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq_core #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic [3:0]         flags
);

   localparam int                 c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
   localparam logic [WIDTH-1:0]   c_min_neg  = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [2:0] c_op_add  = 3'd0;
   localparam logic [2:0] c_op_sub  = 3'd1;
   localparam logic [2:0] c_op_nega = 3'd2;
   localparam logic [2:0] c_op_negb = 3'd3;
   localparam logic [2:0] c_op_and  = 3'd4;
   localparam logic [2:0] c_op_or   = 3'd5;
   localparam logic [2:0] c_op_xor  = 3'd6;
   localparam logic [2:0] c_op_mul  = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic                 r_in_ready;
   logic                 w_accept;

   logic [2*WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [2*WIDTH-1:0]   r_acc;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [2*WIDTH-1:0]   w_acc_next;
   logic                 w_mul_last;
   logic [3:0]           w_mul_flags;

   logic [2*WIDTH-1:0]   r_result;
   logic [3:0]           r_flags;

   logic [WIDTH:0]       w_sum;
   logic [WIDTH:0]       w_diff;
   logic [WIDTH-1:0]     w_alu_res;
   logic                 w_alu_c;
   logic                 w_alu_v;
   logic [3:0]           w_alu_flags;

   // Single-cycle datapath; evaluated only on the accept edge
   always_comb begin
      w_sum     = {1'b0, a} + {1'b0, b};
      w_diff    = {1'b0, a} - {1'b0, b};
      w_alu_res = '0;
      w_alu_c   = 1'b0;
      w_alu_v   = 1'b0;
      case (op)
         c_op_add: begin
            w_alu_res = w_sum[WIDTH-1:0];
            w_alu_c   = w_sum[WIDTH];
            w_alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
         end
         c_op_sub: begin
            w_alu_res = w_diff[WIDTH-1:0];
            w_alu_c   = w_diff[WIDTH];
            w_alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
         end
         c_op_nega: begin
            w_alu_res = (~a) + WIDTH'(1);
            w_alu_v   = (a == c_min_neg);
         end
         c_op_negb: begin
            w_alu_res = (~b) + WIDTH'(1);
            w_alu_v   = (b == c_min_neg);
         end
         c_op_and: w_alu_res = a & b;
         c_op_or:  w_alu_res = a | b;
         c_op_xor: w_alu_res = a ^ b;
         default:  w_alu_res = '0;
      endcase
      w_alu_flags = {w_alu_c, w_alu_v, w_alu_res[WIDTH-1], ~|w_alu_res};
   end

   // One shift-add step per MUL cycle, multiplier consumed LSB first
   always_comb begin
      w_acc_next  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
      w_mul_last  = (r_state == S_MUL) && (r_cnt == c_cnt_last);
      w_mul_flags = {2'b00, w_acc_next[2*WIDTH-1], ~|w_acc_next};
   end

   always_comb begin
      w_accept     = in_valid & r_in_ready;
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_next = (op == c_op_mul) ? S_MUL : S_DONE;
            end
         end
         S_MUL: begin
            if (r_cnt == c_cnt_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_in_ready <= 1'b0;
         r_mcand    <= '0;
         r_mplier   <= '0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_result   <= '0;
         r_flags    <= '0;
      end else begin
         r_state    <= w_state_next;
         // Registered so ready stays low through reset and rises one edge after release
         r_in_ready <= (w_state_next == S_IDLE);
         if (w_accept) begin
            if (op == c_op_mul) begin
               r_mcand  <= {{WIDTH{1'b0}}, a};
               r_mplier <= b;
               r_acc    <= '0;
               r_cnt    <= '0;
            end else begin
               r_result <= {{WIDTH{1'b0}}, w_alu_res};
               r_flags  <= w_alu_flags;
            end
         end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + c_cnt_w'(1);
            if (w_mul_last) begin
               r_result <= w_acc_next;
               r_flags  <= w_mul_flags;
            end
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = (r_state == S_DONE);
   assign result    = r_result;
   assign flags     = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_core.sv
// ============================================================================
//  Module   : tb_alu_seq_core
//  Purpose  : Randomized self-checking bench for alu_seq_core at WIDTH=4 and 8.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_seq_core;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        sel8 = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [7:0]  a = 8'd0;
   logic [7:0]  b = 8'd0;

   logic        in_valid4, in_ready4, out_valid4;
   logic [7:0]  result4;
   logic [3:0]  flags4;
   logic        in_valid8, in_ready8, out_valid8;
   logic [15:0] result8;
   logic [3:0]  flags8;

   logic        s_in_ready, s_out_valid;
   logic [15:0] s_result;
   logic [3:0]  s_flags;

   int n_tests = 0;
   int n_fail  = 0;

   assign in_valid4   = in_valid & ~sel8;
   assign in_valid8   = in_valid & sel8;
   assign s_in_ready  = sel8 ? in_ready8  : in_ready4;
   assign s_out_valid = sel8 ? out_valid8 : out_valid4;
   assign s_result    = sel8 ? result8    : {8'h00, result4};
   assign s_flags     = sel8 ? flags8     : flags4;

   always #5 clk = ~clk;

   alu_seq_core #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .op(op), .a(a[3:0]), .b(b[3:0]), .out_valid(out_valid4),
      .out_ready(out_ready), .result(result4), .flags(flags4)
   );

   alu_seq_core #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .op(op), .a(a), .b(b), .out_valid(out_valid8),
      .out_ready(out_ready), .result(result8), .flags(flags8)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: arithmetic on plain integers, masked to the operand width
   function automatic void model(input int w, input int opc, input int unsigned av,
                                 input int unsigned bv, output int unsigned res,
                                 output logic [3:0] fl);
      int unsigned mask, x, y, r, full;
      bit c, v, n, sx, sy, sr;
      mask = (32'd1 << w) - 1;
      x = av & mask;
      y = bv & mask;
      c = 0; v = 0; r = 0;
      sx = x[w-1];
      sy = y[w-1];
      case (opc)
         0: begin full = x + y; r = full & mask; c = (full > mask); end
         1: begin r = (x - y) & mask; c = (x < y); end
         2: begin r = (0 - x) & mask; v = (x == (32'd1 << (w-1))); end
         3: begin r = (0 - y) & mask; v = (y == (32'd1 << (w-1))); end
         4: r = x & y;
         5: r = x | y;
         6: r = x ^ y;
         default: r = x * y;
      endcase
      sr = r[w-1];
      if (opc == 0) v = (sx == sy) && (sr != sx);
      if (opc == 1) v = (sx != sy) && (sr != sx);
      n = (opc == 7) ? r[2*w-1] : r[w-1];
      res = r;
      fl = {c, v, n, (r == 0)};
   endfunction

   task automatic do_op(input bit w8, input int opc, input int unsigned av,
                        input int unsigned bv, input int hold);
      int unsigned exp_r;
      logic [3:0]  exp_f;
      int          wd, lat, budget;
      wd = w8 ? 8 : 4;
      model(wd, opc, av, bv, exp_r, exp_f);
      @(negedge clk);
      sel8 = w8; op = opc[2:0]; a = av[7:0]; b = bv[7:0];
      in_valid = 1'b1; out_ready = 1'b0;
      budget = 0;
      while (!s_in_ready && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      check("accept_ready", s_in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      lat = 1;
      while (!s_out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, (opc == 7) ? wd + 1 : 1);
      check("out_valid", s_out_valid, 1);
      check("result", s_result, exp_r[15:0]);
      check("flags", s_flags, exp_f);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_result", s_result, exp_r[15:0]);
         check("hold_flags", s_flags, exp_f);
         check("hold_valid", s_out_valid, 1);
         check("hold_in_ready", s_in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("release_valid", s_out_valid, 0);
      check("release_in_ready", s_in_ready, 1);
      check("kept_result", s_result, exp_r[15:0]);
   endtask

   initial begin
      int cnt;
      #2 rst_n = 1'b0;
      #1;
      check("rst_out_valid", out_valid4, 0);
      check("rst_result", result4, 0);
      check("rst_flags", flags4, 0);
      check("rst_in_ready", in_ready4, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_release_ready", in_ready4, 1);

      // Directed cases at WIDTH=4
      do_op(0, 0, 9, 8, 0);
      check("add_98_result", s_result, 16'h0001);
      check("add_98_flags", s_flags, 4'b1100);
      do_op(0, 1, 3, 5, 1);
      check("sub_35_flags", s_flags, 4'b1010);
      do_op(0, 7, 15, 15, 0);
      check("mul_ff_result", s_result, 16'h00E1);
      check("mul_ff_flags", s_flags, 4'b0010);
      do_op(0, 7, 0, 7, 0);
      do_op(0, 2, 8, 0, 0);
      check("nega_8_flags", s_flags, 4'b0110);
      do_op(0, 3, 0, 0, 0);
      do_op(0, 6, 10, 10, 0);

      // Backpressure with a pending op held on the inputs
      @(negedge clk);
      sel8 = 0; op = 3'd0; a = 8'd2; b = 8'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      op = 3'd4; a = 8'h0C; b = 8'h0A;
      check("bp_valid", out_valid4, 1);
      check("bp_result", result4, 8'h05);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("bp_hold_result", result4, 8'h05);
         check("bp_hold_ready", in_ready4, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_idle_ready", in_ready4, 1);
      check("bp_idle_valid", out_valid4, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_pending_valid", out_valid4, 1);
      check("bp_pending_result", result4, 8'h08);
      check("bp_pending_flags", flags4, 4'b0010);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset while in DONE
      @(negedge clk);
      op = 3'd0; a = 8'd9; b = 8'd8; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_done_valid", out_valid4, 0);
      check("rst_done_result", result4, 0);
      check("rst_done_flags", flags4, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_done_ready", in_ready4, 1);

      // Reset mid-MUL at WIDTH=8, then a full-scale product
      @(negedge clk);
      sel8 = 1; op = 3'd7; a = 8'd3; b = 8'd5; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("rst_mul_valid", out_valid8, 0);
      check("rst_mul_result", result8, 0);
      @(negedge clk) rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid8) cnt++;
      end
      check("no_stale_valid", cnt, 0);
      do_op(1, 7, 8'hFF, 8'hFF, 1);
      check("mul8_result", s_result, 16'hFE01);

      // Randomized traffic on both widths
      for (int i = 0; i < 60; i++) begin
         do_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
               $urandom, $urandom, int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

`default_nettype wire
